// File: rtl/quat_mult_pkg.sv
// Shared constants for the pipelined quaternion multiplier.
// Optional conjugate mode (quat_mult_pipe) is enabled by defining QMUL_CONJ_EN.
package quat_mult_pkg;

  localparam int PIPE_DEPTH = 3;

  localparam int LANE_R = 0;
  localparam int LANE_I = 1;
  localparam int LANE_J = 2;
  localparam int LANE_K = 3;

  // Bit [4*lane+i] set: term a_i * b_(lane^i) is subtracted in output lane.
  localparam logic [15:0] PROD_NEG = 16'h428E;

  function automatic int acc_width(input int data_w);
    return 2 * data_w + 2;
  endfunction

endpackage

// File: rtl/quat_mult_pipe_sat_round.sv
// One output lane: optional round-half-up, arithmetic right shift, clamp to OUT_W.
// Sized one bit wider than both accumulator and output so nothing wraps before the clamp.
module quat_sat_round #(
  parameter int ACC_W  = 34,
  parameter int FRAC_W = 0,
  parameter int OUT_W  = 34
) (
  input  logic signed [ACC_W-1:0] acc,
  output logic signed [OUT_W-1:0] res,
  output logic                    sat
);

  localparam int WW = ((OUT_W > ACC_W) ? OUT_W : ACC_W) + 1;

  logic signed [WW-1:0] ext;
  logic signed [WW-1:0] shf;
  logic                 fits;

  assign ext = WW'(acc);

  generate
    if (FRAC_W > 0) begin : g_rnd
      localparam logic signed [WW-1:0] RND = {{(WW-1){1'b0}}, 1'b1} << (FRAC_W - 1);
      assign shf = (ext + RND) >>> FRAC_W;
    end else begin : g_nornd
      assign shf = ext;
    end
  endgenerate

  // Representable iff every bit from the output sign bit upward agrees.
  assign fits = (&shf[WW-1:OUT_W-1]) | ~(|shf[WW-1:OUT_W-1]);
  assign sat  = ~fits;
  assign res  = fits ? shf[OUT_W-1:0] : {shf[WW-1], {(OUT_W-1){~shf[WW-1]}}};

endmodule

// File: rtl/quat_mult_pipe.sv
// 3-stage Hamilton product c = a*b with valid/ready on both sides.
// Define QMUL_CONJ_EN to add the in_conj port (per-beat c = a*conj(b)).
module quat_mult_pipe
  import quat_mult_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int FRAC_W = 0,
  parameter int OUT_W  = 2 * DATA_W + 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*DATA_W-1:0]   a_in,
  input  logic [4*DATA_W-1:0]   b_in,
`ifdef QMUL_CONJ_EN
  input  logic                  in_conj,
`endif
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*OUT_W-1:0]    c_out,
  output logic [3:0]            out_sat
);

  localparam int ACC_W = acc_width(DATA_W);

  logic v1, v2, v3;
  logic s1_load, s2_load, s3_load;

  logic signed [DATA_W:0]  b_eff  [4];
  logic signed [ACC_W-1:0] prod_d [16];
  logic signed [ACC_W-1:0] prod_q [16];
  logic signed [ACC_W-1:0] sum_d  [4];
  logic signed [ACC_W-1:0] sum_q  [4];
  logic signed [OUT_W-1:0] lane_d [4];
  logic [3:0]              sat_d;
  logic [4*OUT_W-1:0]      c_d;

  assign s3_load   = !v3 || out_ready;
  assign s2_load   = !v2 || s3_load;
  assign s1_load   = !v1 || s2_load;
  assign in_ready  = s1_load;
  assign out_valid = v3;

  // One extra bit so negating the most negative b lane is exact.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      b_eff[i] = (DATA_W+1)'($signed(b_in[i*DATA_W +: DATA_W]));
`ifdef QMUL_CONJ_EN
      if (in_conj && i != LANE_R) b_eff[i] = -b_eff[i];
`endif
    end
  end

  always_comb begin : s1_products
    logic signed [ACC_W-1:0] p;
    p = '0;
    prod_d = '{default: '0};
    for (int l = 0; l < 4; l++) begin
      for (int i = 0; i < 4; i++) begin
        p = ACC_W'($signed(a_in[i*DATA_W +: DATA_W])) * ACC_W'(b_eff[l ^ i]);
        prod_d[4*l+i] = PROD_NEG[4*l+i] ? -p : p;
      end
    end
  end

  always_comb begin
    for (int l = 0; l < 4; l++) begin
      sum_d[l] = prod_q[4*l] + prod_q[4*l+1] + prod_q[4*l+2] + prod_q[4*l+3];
    end
  end

  generate
    for (genvar l = 0; l < 4; l++) begin : g_lane
      quat_sat_round #(
        .ACC_W  (ACC_W),
        .FRAC_W (FRAC_W),
        .OUT_W  (OUT_W)
      ) u_sat_round (
        .acc (sum_q[l]),
        .res (lane_d[l]),
        .sat (sat_d[l])
      );
    end
  endgenerate

  always_comb begin
    c_d = '0;
    for (int l = 0; l < 4; l++) c_d[l*OUT_W +: OUT_W] = lane_d[l];
  end

  // Output regs are cleared so c_out reads 0 straight after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1      <= 1'b0;
      v2      <= 1'b0;
      v3      <= 1'b0;
      c_out   <= '0;
      out_sat <= '0;
    end else begin
      if (s1_load) v1 <= in_valid;
      if (s2_load) v2 <= v1;
      if (s3_load) begin
        v3 <= v2;
        if (v2) begin
          c_out   <= c_d;
          out_sat <= sat_d;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (s1_load && in_valid) prod_q <= prod_d;
    if (s2_load && v1)       sum_q  <= sum_d;
  end

endmodule

// File: tb/tb_quat_mult_pipe.sv
// Directed bench for quat_mult_pipe: default, 16-bit saturating and FRAC_W=1 instances share stimulus.
// Conjugate case is exercised when QMUL_CONJ_EN is defined.
module tb_quat_mult_pipe;

  localparam int DW  = 16;
  localparam int OW  = 34;
  localparam int OWS = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic out_ready = 1'b1;
  logic [4*DW-1:0] a_in = '0;
  logic [4*DW-1:0] b_in = '0;
`ifdef QMUL_CONJ_EN
  logic in_conj = 1'b0;
`endif

  logic in_ready, out_valid;
  logic [4*OW-1:0] c_out;
  logic [3:0] out_sat;
  logic in_ready_s, out_valid_s;
  logic [4*OWS-1:0] c_out_s;
  logic [3:0] out_sat_s;
  logic in_ready_r, out_valid_r;
  logic [4*OW-1:0] c_out_r;
  logic [3:0] out_sat_r;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  quat_mult_pipe #(.DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a_in(a_in), .b_in(b_in),
`ifdef QMUL_CONJ_EN
    .in_conj(in_conj),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .c_out(c_out), .out_sat(out_sat)
  );

  quat_mult_pipe #(.DATA_W(DW), .FRAC_W(0), .OUT_W(OWS)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s),
    .a_in(a_in), .b_in(b_in),
`ifdef QMUL_CONJ_EN
    .in_conj(in_conj),
`endif
    .out_valid(out_valid_s), .out_ready(out_ready), .c_out(c_out_s), .out_sat(out_sat_s)
  );

  quat_mult_pipe #(.DATA_W(DW), .FRAC_W(1)) dut_rnd (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_r),
    .a_in(a_in), .b_in(b_in),
`ifdef QMUL_CONJ_EN
    .in_conj(in_conj),
`endif
    .out_valid(out_valid_r), .out_ready(out_ready), .c_out(c_out_r), .out_sat(out_sat_r)
  );

  function automatic logic [4*DW-1:0] pack4(input int x0, input int x1, input int x2, input int x3);
    return {16'(x3), 16'(x2), 16'(x1), 16'(x0)};
  endfunction

  function automatic longint lw(input logic [4*OW-1:0] v, input int i);
    logic signed [OW-1:0] t;
    t = v[i*OW +: OW];
    return longint'(t);
  endfunction

  function automatic longint ln(input logic [4*OWS-1:0] v, input int i);
    logic signed [OWS-1:0] t;
    t = v[i*OWS +: OWS];
    return longint'(t);
  endfunction

  // Drive one beat, then wait (bounded) for its result; lat counts edges from accept, 0 on timeout.
  task automatic do_beat(input logic [4*DW-1:0] a, input logic [4*DW-1:0] b, output int lat);
    int guard;
    a_in = a;
    b_in = b;
    in_valid = 1'b1;
    guard = 0;
    while (!in_ready && guard < 10) begin
      @(posedge clk); #1;
      guard++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid) lat = 0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset out_valid: got %b want 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset in_ready: got %b want 1", in_ready); end
    n_cmp++; if (c_out !== '0) begin n_bad++; $display("FAIL reset c_out: got %h want 0", c_out); end
    n_cmp++; if (out_sat !== 4'b0000) begin n_bad++; $display("FAIL reset out_sat: got %b want 0000", out_sat); end
    n_cmp++; if (c_out_s !== '0 || out_sat_s !== 4'b0000) begin n_bad++; $display("FAIL reset sat_inst: got %h/%b want 0/0000", c_out_s, out_sat_s); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_identity;
    int lat;
    longint e[4] = '{5, 6, 7, 8};
    do_beat(pack4(1, 0, 0, 0), pack4(5, 6, 7, 8), lat);
    n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL identity latency: got %0d want 3", lat); end
    for (int l = 0; l < 4; l++) begin
      n_cmp++; if (lw(c_out, l) !== e[l]) begin n_bad++; $display("FAIL identity c%0d: got %0d want %0d", l, lw(c_out, l), e[l]); end
    end
    n_cmp++; if (out_sat !== 4'b0000) begin n_bad++; $display("FAIL identity out_sat: got %b want 0000", out_sat); end
    @(posedge clk); #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL identity drain: out_valid got %b want 0", out_valid); end
  endtask

  task automatic test_basis;
    int lat;
    longint ij[4] = '{0, 0, 0, 1};
    longint ji[4] = '{0, 0, 0, -1};
    do_beat(pack4(0, 1, 0, 0), pack4(0, 0, 1, 0), lat);
    for (int l = 0; l < 4; l++) begin
      n_cmp++; if (lw(c_out, l) !== ij[l]) begin n_bad++; $display("FAIL basis_ij c%0d: got %0d want %0d", l, lw(c_out, l), ij[l]); end
    end
    @(posedge clk); #1;
    do_beat(pack4(0, 0, 1, 0), pack4(0, 1, 0, 0), lat);
    for (int l = 0; l < 4; l++) begin
      n_cmp++; if (lw(c_out, l) !== ji[l]) begin n_bad++; $display("FAIL basis_ji c%0d: got %0d want %0d", l, lw(c_out, l), ji[l]); end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_general;
    int lat;
    longint e[4]  = '{-60, 12, 30, 24};
    longint er[4] = '{-30, 6, 15, 12};
    do_beat(pack4(1, 2, 3, 4), pack4(5, 6, 7, 8), lat);
    for (int l = 0; l < 4; l++) begin
      n_cmp++; if (lw(c_out, l) !== e[l]) begin n_bad++; $display("FAIL general c%0d: got %0d want %0d", l, lw(c_out, l), e[l]); end
      n_cmp++; if (ln(c_out_s, l) !== e[l]) begin n_bad++; $display("FAIL general_sat c%0d: got %0d want %0d", l, ln(c_out_s, l), e[l]); end
      n_cmp++; if (lw(c_out_r, l) !== er[l]) begin n_bad++; $display("FAIL general_rnd c%0d: got %0d want %0d", l, lw(c_out_r, l), er[l]); end
    end
    n_cmp++; if (out_sat_s !== 4'b0000) begin n_bad++; $display("FAIL general_sat flags: got %b want 0000", out_sat_s); end
    @(posedge clk); #1;
  endtask

  task automatic test_saturation;
    int lat;
    longint big = longint'(1) <<< 31;
    longint ed[4];
    longint es[4] = '{-32768, 32767, 32767, 32767};
    longint er[4];
    ed = '{-big, big, big, big};
    er = '{-(big / 2), big / 2, big / 2, big / 2};
    do_beat(pack4(32767, 0, 0, 0), pack4(32767, 0, 0, 0), lat);
    n_cmp++; if (ln(c_out_s, 0) !== 32767) begin n_bad++; $display("FAIL sat_pos c0: got %0d want 32767", ln(c_out_s, 0)); end
    n_cmp++; if (out_sat_s !== 4'b0001) begin n_bad++; $display("FAIL sat_pos flags: got %b want 0001", out_sat_s); end
    n_cmp++; if (lw(c_out, 0) !== 1073676289) begin n_bad++; $display("FAIL sat_pos wide c0: got %0d want 1073676289", lw(c_out, 0)); end
    n_cmp++; if (out_sat !== 4'b0000) begin n_bad++; $display("FAIL sat_pos wide flags: got %b want 0000", out_sat); end
    @(posedge clk); #1;
    do_beat(pack4(32767, 0, 0, 0), pack4(-32768, 0, 0, 0), lat);
    n_cmp++; if (ln(c_out_s, 0) !== -32768) begin n_bad++; $display("FAIL sat_neg c0: got %0d want -32768", ln(c_out_s, 0)); end
    n_cmp++; if (out_sat_s !== 4'b0001) begin n_bad++; $display("FAIL sat_neg flags: got %b want 0001", out_sat_s); end
    @(posedge clk); #1;
    do_beat(pack4(-32768, -32768, -32768, -32768), pack4(-32768, -32768, -32768, -32768), lat);
    for (int l = 0; l < 4; l++) begin
      n_cmp++; if (lw(c_out, l) !== ed[l]) begin n_bad++; $display("FAIL extreme c%0d: got %0d want %0d", l, lw(c_out, l), ed[l]); end
      n_cmp++; if (ln(c_out_s, l) !== es[l]) begin n_bad++; $display("FAIL extreme_sat c%0d: got %0d want %0d", l, ln(c_out_s, l), es[l]); end
      n_cmp++; if (lw(c_out_r, l) !== er[l]) begin n_bad++; $display("FAIL extreme_rnd c%0d: got %0d want %0d", l, lw(c_out_r, l), er[l]); end
    end
    n_cmp++; if (out_sat !== 4'b0000) begin n_bad++; $display("FAIL extreme flags: got %b want 0000", out_sat); end
    n_cmp++; if (out_sat_s !== 4'b1111) begin n_bad++; $display("FAIL extreme_sat flags: got %b want 1111", out_sat_s); end
    @(posedge clk); #1;
  endtask

  task automatic test_rounding;
    int lat;
    int av[4]  = '{3, -3, 1, -1};
    int exp_r[4] = '{2, -1, 1, 0};
    for (int k = 0; k < 4; k++) begin
      do_beat(pack4(av[k], 0, 0, 0), pack4(1, 0, 0, 0), lat);
      n_cmp++; if (lw(c_out_r, 0) !== longint'(exp_r[k])) begin n_bad++; $display("FAIL round c0 from %0d: got %0d want %0d", av[k], lw(c_out_r, 0), exp_r[k]); end
      n_cmp++; if (out_sat_r !== 4'b0000) begin n_bad++; $display("FAIL round flags: got %b want 0000", out_sat_r); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back;
    int got = 0;
    out_ready = 1'b1;
    b_in = pack4(1, 2, 3, 4);
    for (int cyc = 0; cyc < 14; cyc++) begin
      in_valid = (cyc < 4);
      a_in = pack4(cyc + 1, 0, 0, 0);
      #1;
      if (cyc < 4) begin
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL b2b in_ready cyc%0d: got %b want 1", cyc, in_ready); end
      end
      if (out_valid) begin
        n_cmp++; if (cyc !== got + 3) begin n_bad++; $display("FAIL b2b timing beat%0d: got cyc %0d want %0d", got, cyc, got + 3); end
        n_cmp++; if (lw(c_out, 1) !== longint'(2 * (got + 1))) begin n_bad++; $display("FAIL b2b c1 beat%0d: got %0d want %0d", got, lw(c_out, 1), 2 * (got + 1)); end
        got++;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    n_cmp++; if (got !== 4) begin n_bad++; $display("FAIL b2b count: got %0d want 4", got); end
  endtask

  task automatic test_backpressure;
    int sent = 0;
    int got = 0;
    b_in = pack4(1, 2, 3, 4);
    for (int cyc = 0; cyc < 50 && got < 8; cyc++) begin
      out_ready = (cyc >= 6);
      in_valid = (sent < 8);
      a_in = pack4(sent + 1, 0, 0, 0);
      #1;
      if (cyc == 3 || cyc == 5) begin
        n_cmp++; if (out_valid !== 1'b1 || lw(c_out, 0) !== 1 || lw(c_out, 3) !== 4) begin
          n_bad++; $display("FAIL bp hold cyc%0d: got v=%b c0=%0d c3=%0d want v=1 c0=1 c3=4", cyc, out_valid, lw(c_out, 0), lw(c_out, 3));
        end
      end
      if (cyc == 5) begin
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp in_ready full: got %b want 0", in_ready); end
        n_cmp++; if (sent !== 3) begin n_bad++; $display("FAIL bp accepted while stalled: got %0d want 3", sent); end
      end
      if (out_valid && out_ready) begin
        n_cmp++; if (lw(c_out, 0) !== longint'(got + 1) || lw(c_out, 3) !== longint'(4 * (got + 1))) begin
          n_bad++; $display("FAIL bp order beat%0d: got c0=%0d c3=%0d want %0d %0d", got, lw(c_out, 0), lw(c_out, 3), got + 1, 4 * (got + 1));
        end
        got++;
      end
      if (in_valid && in_ready) sent++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    n_cmp++; if (got !== 8) begin n_bad++; $display("FAIL bp count: got %0d want 8", got); end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset_midstream;
    int got = 0;
    out_ready = 1'b0;
    b_in = pack4(1, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      a_in = pack4(k + 10, 0, 0, 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL midrst out_valid: got %b want 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL midrst in_ready: got %b want 1", in_ready); end
    n_cmp++; if (c_out !== '0) begin n_bad++; $display("FAIL midrst c_out: got %h want 0", c_out); end
    out_ready = 1'b1;
    in_valid = 1'b1;
    a_in = pack4(42, 0, 0, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      if (out_valid) begin
        got++;
        n_cmp++; if (lw(c_out, 0) !== 42) begin n_bad++; $display("FAIL midrst result c0: got %0d want 42", lw(c_out, 0)); end
      end
      @(posedge clk); #1;
    end
    n_cmp++; if (got !== 1) begin n_bad++; $display("FAIL midrst result count: got %0d want 1", got); end
  endtask

`ifdef QMUL_CONJ_EN
  task automatic test_conj;
    int lat;
    longint e[4] = '{30, 0, 0, 0};
    in_conj = 1'b1;
    do_beat(pack4(1, 2, 3, 4), pack4(1, 2, 3, 4), lat);
    in_conj = 1'b0;
    for (int l = 0; l < 4; l++) begin
      n_cmp++; if (lw(c_out, l) !== e[l]) begin n_bad++; $display("FAIL conj c%0d: got %0d want %0d", l, lw(c_out, l), e[l]); end
    end
    @(posedge clk); #1;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_identity();
    test_basis();
    test_general();
    test_saturation();
    test_rounding();
    test_back_to_back();
    test_backpressure();
    test_reset_midstream();
`ifdef QMUL_CONJ_EN
    test_conj();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
